// File: rtl/seg7_scan.sv
// Multiplexed 4-digit common-anode seven-segment scanner with frame-synchronous value swap.
// Optional feature: define SEG7_LZB_EN to blank leading-zero digits (digit 0 is always lit).
module seg7_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD,
    input  logic [15:0] D,
    input  logic        EN,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic        FRAME
);

    localparam int MAX_A   = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int MAX_CNT = (MAX_A > 2) ? MAX_A : 2;
    localparam int DIV_W   = $clog2(MAX_CNT);
    localparam logic [DIV_W-1:0] SHOW_TC = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_TC  = DIV_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  w_div_nx;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_nx;
    logic              w_adv;
    logic              w_wrap;
    logic [15:0]       r_shadow;
    logic [15:0]       r_disp;
    logic              r_pend;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [3:0]        w_an_nx;
    logic [6:0]        w_seg_nx;
    logic [6:0]        r_seg;
    logic [3:0]        r_an;
    logic              r_frame;

    // Hex to active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b0000001;
            4'h1:    hex7 = 7'b1001111;
            4'h2:    hex7 = 7'b0010010;
            4'h3:    hex7 = 7'b0000110;
            4'h4:    hex7 = 7'b1001100;
            4'h5:    hex7 = 7'b0100100;
            4'h6:    hex7 = 7'b0100000;
            4'h7:    hex7 = 7'b0001111;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0000100;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b1100000;
            4'hC:    hex7 = 7'b0110001;
            4'hD:    hex7 = 7'b1000010;
            4'hE:    hex7 = 7'b0110000;
            4'hF:    hex7 = 7'b0111000;
            default: hex7 = 7'b1111111;
        endcase
    endfunction

    // Scan FSM next state: dwell counter, gap insertion and digit advance
    always_comb begin
        w_state_nx = r_state;
        w_div_nx   = r_div + {{(DIV_W-1){1'b0}}, 1'b1};
        w_adv      = 1'b0;
        case (r_state)
            ST_SHOW: begin
                if (r_div == SHOW_TC) begin
                    w_div_nx = {DIV_W{1'b0}};
                    if (GAP_CYC > 0) begin
                        w_state_nx = ST_GAP;
                    end else begin
                        w_adv = 1'b1;
                    end
                end else begin
                    w_state_nx = ST_SHOW;
                end
            end
            ST_GAP: begin
                if (r_div == GAP_TC) begin
                    w_div_nx   = {DIV_W{1'b0}};
                    w_state_nx = ST_SHOW;
                    w_adv      = 1'b1;
                end else begin
                    w_state_nx = ST_GAP;
                end
            end
            default: begin
                w_state_nx = ST_SHOW;
                w_div_nx   = {DIV_W{1'b0}};
            end
        endcase
        w_idx_nx = w_adv ? (r_idx + 2'd1) : r_idx;
        w_wrap   = w_adv && (r_idx == 2'd3);
    end

    // Digit data select, optional leading-zero blanking and output encoding
    always_comb begin
        case (r_idx)
            2'd0:    w_nib = r_disp[3:0];
            2'd1:    w_nib = r_disp[7:4];
            2'd2:    w_nib = r_disp[11:8];
            2'd3:    w_nib = r_disp[15:12];
            default: w_nib = 4'h0;
        endcase
`ifdef SEG7_LZB_EN
        case (r_idx)
            2'd1:    w_blank = (r_disp[15:4] == 12'h000);
            2'd2:    w_blank = (r_disp[15:8] == 8'h00);
            2'd3:    w_blank = (r_disp[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
        w_an_nx  = 4'b1111;
        w_seg_nx = 7'b1111111;
        if (EN && (r_state == ST_SHOW)) begin
            w_seg_nx = hex7(w_nib);
            if (!w_blank) begin
                w_an_nx = ~(4'b0001 << r_idx);
            end else begin
                w_an_nx = 4'b1111;
            end
        end else begin
            w_an_nx  = 4'b1111;
            w_seg_nx = 7'b1111111;
        end
    end

    // State, counters, shadow/display swap and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= ST_SHOW;
            r_div    <= {DIV_W{1'b0}};
            r_idx    <= 2'd0;
            r_shadow <= 16'h0000;
            r_disp   <= 16'h0000;
            r_pend   <= 1'b0;
            r_an     <= 4'b1111;
            r_seg    <= 7'b1111111;
            r_frame  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_div   <= w_div_nx;
            r_idx   <= w_idx_nx;
            r_an    <= w_an_nx;
            r_seg   <= w_seg_nx;
            r_frame <= w_wrap;
            // A LOAD coinciding with the swap keeps pend set for the next frame
            if (LOAD) begin
                r_shadow <= D;
                r_pend   <= 1'b1;
            end else if (w_wrap) begin
                r_pend   <= 1'b0;
            end else begin
                r_pend   <= r_pend;
            end
            if (w_wrap && r_pend) begin
                r_disp <= r_shadow;
            end else begin
                r_disp <= r_disp;
            end
        end
    end

    assign SEG   = r_seg;
    assign AN    = r_an;
    assign FRAME = r_frame;

endmodule
